// File: rtl/seg7_pkg.sv
// Shared constants and the segment decode function for the multiplexed
// 4-digit seven-segment display driver.
package seg7_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [3:0] AN_OFF     = 4'hF;

    // Active-low {g,f,e,d,c,b,a}; entry 0 is the rightmost slice.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    typedef enum logic [1:0] {
        SLOT_GAP,
        SLOT_SHOW,
        SLOT_SUPP
    } slot_e;

    function automatic logic [6:0] seg7_decode(input logic [3:0] val, input logic hex_en);
        if (val >= 4'd10 && !hex_en) return SEG_BLANK;
        return SEG_LUT[val];
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Digit/control inputs and the seg/an pin outputs of the scan driver.
interface seg7_scan_driver_if;
    logic [15:0] digits;
    logic        blink_en;
    logic [3:0]  blink_mask;
    logic        lz_blank;
    logic [6:0]  seg;
    logic [3:0]  an;

    modport master (output digits, blink_en, blink_mask, lz_blank, input seg, an);
    modport slave  (input digits, blink_en, blink_mask, lz_blank, output seg, an);
endinterface

// File: rtl/seg7_scan_driver_decoder.sv
// Combinational 4-bit value to active-low seven-segment pattern.
module seg7_decoder
    import seg7_pkg::*;
#(
    parameter bit HEX_EN = 1'b0
) (
    input  logic [3:0] val,
    output logic [6:0] seg
);
    assign seg = seg7_decode(val, HEX_EN);
endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit seven-segment driver with guard gap, per-digit
// blink and leading-zero blanking; seg/an are registered.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int GUARD     = 1000,
    parameter int BLINK_DIV = 25000000,
    parameter bit HEX_EN    = 1'b0
) (
    input logic              clk,
    input logic              rst,
    seg7_scan_driver_if.slave bus
);
    localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] GUARD_C    = SW'(GUARD);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [SW-1:0] scan_cnt;
    logic [1:0]    idx;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic [6:0]    seg_q, seg_nxt;
    logic [3:0]    an_q, an_nxt;
    slot_e         slot;

    logic [NUM_DIGITS-1:0][3:0] dig;
    logic [NUM_DIGITS-1:0][6:0] dec;
    logic [NUM_DIGITS-1:0]      lz_sup;
    logic                       blink_sup;

    assign dig = bus.digits;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
        seg7_decoder #(.HEX_EN(HEX_EN)) u_dec (.val(dig[i]), .seg(dec[i]));
    end

    // Each blanked leading zero requires every more-significant digit blanked too.
    assign lz_sup[3] = bus.lz_blank && (dig[3] == 4'd0);
    assign lz_sup[2] = lz_sup[3] && (dig[2] == 4'd0);
    assign lz_sup[1] = lz_sup[2] && (dig[1] == 4'd0);
    assign lz_sup[0] = 1'b0;

    assign blink_sup = bus.blink_en && bus.blink_mask[idx] && blink_phase;

    always_comb begin
        slot    = SLOT_GAP;
        seg_nxt = SEG_BLANK;
        an_nxt  = AN_OFF;
        if (scan_cnt >= GUARD_C)
            slot = (blink_sup || lz_sup[idx]) ? SLOT_SUPP : SLOT_SHOW;
        case (slot)
            SLOT_SHOW: begin
                seg_nxt = dec[idx];
                an_nxt  = ~(4'b0001 << idx);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt    <= '0;
            idx         <= 2'd0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            seg_q       <= SEG_BLANK;
            an_q        <= AN_OFF;
        end else begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                idx      <= idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
            seg_q <= seg_nxt;
            an_q  <= an_nxt;
        end
    end

    assign bus.seg = seg_q;
    assign bus.an  = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Table-driven scoreboard bench for seg7_scan_driver (SCAN_DIV=4, GUARD=1,
// BLINK_DIV=32) with a HEX_EN=0 and a HEX_EN=1 instance on shared inputs.
module tb_seg7_scan_driver;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S7 = 7'b1111000,
                           S9 = 7'b0010000, SA = 7'b0001000, SB = 7'b0000011,
                           SC = 7'b1000110, SF = 7'b0001110, SX = 7'h7F;

    typedef struct packed {
        logic [15:0]     digits;
        logic            lz;
        logic            blink_en;
        logic [3:0]      mask;
        logic            hex;
        logic [3:0]      on;
        logic [3:0][6:0] seg;
        int              ncyc;
    } vec_t;

    typedef struct packed {
        logic       hex;
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   k, checks, errors;
    exp_t sb[$];
    vec_t tbl[8];

    seg7_scan_driver_if bus0();
    seg7_scan_driver_if bus1();

    assign bus1.digits     = bus0.digits;
    assign bus1.blink_en   = bus0.blink_en;
    assign bus1.blink_mask = bus0.blink_mask;
    assign bus1.lz_blank   = bus0.lz_blank;

    seg7_scan_driver #(.SCAN_DIV(4), .GUARD(1), .BLINK_DIV(32), .HEX_EN(1'b0))
        dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    seg7_scan_driver #(.SCAN_DIV(4), .GUARD(1), .BLINK_DIV(32), .HEX_EN(1'b1))
        dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s k=%0d: got an=%h seg=%b, want an=%h seg=%b",
                     name, k, act[10:7], act[6:0], req[10:7], req[6:0]);
        end
    endtask

    task automatic check_hot(input logic [3:0] an);
        checks++;
        if ($countones(~an) > 1) begin
            errors++;
            $display("FAIL onehot k=%0d: got an=%b, want at most one low bit", k, an);
        end
    endtask

    // Output after the k-th edge since reset release reflects the counters
    // as they stood after edge k-1.
    function automatic exp_t expect_out(input int kk, input vec_t v);
        int   pos, id;
        logic ph;
        exp_t e;
        pos   = (kk - 1) % 4;
        id    = ((kk - 1) / 4) % 4;
        ph    = (((kk - 1) / 32) % 2) == 1;
        e.hex = v.hex;
        e.an  = 4'hF;
        e.seg = SX;
        if (pos != 0 && v.on[id] && !(v.blink_en && v.mask[id] && ph)) begin
            e.an  = ~(4'b0001 << id);
            e.seg = v.seg[id];
        end
        return e;
    endfunction

    task automatic apply(input vec_t v);
        bus0.digits     = v.digits;
        bus0.lz_blank   = v.lz;
        bus0.blink_en   = v.blink_en;
        bus0.blink_mask = v.mask;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset0", {bus0.an, bus0.seg}, {4'hF, SX});
        check("reset1", {bus1.an, bus1.seg}, {4'hF, SX});
        @(negedge clk);
        rst = 1'b0;
        k   = 0;
    endtask

    task automatic step(input vec_t v);
        exp_t e;
        logic [10:0] act;
        @(posedge clk);
        k++;
        sb.push_back(expect_out(k, v));
        @(negedge clk);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard k=%0d: got empty queue, want one entry", k);
        end else begin
            e   = sb.pop_front();
            act = e.hex ? {bus1.an, bus1.seg} : {bus0.an, bus0.seg};
            check(e.hex ? "scan_hex" : "scan", act, {e.an, e.seg});
            check_hot(act[10:7]);
        end
    endtask

    initial begin
        vec_t v;
        checks = 0;
        errors = 0;
        k      = 0;

        tbl[0] = '{digits:16'h1234, lz:1'b0, blink_en:1'b0, mask:4'h0, hex:1'b0,
                   on:4'hF, seg:{S1, S2, S3, S4}, ncyc:20};
        tbl[1] = '{digits:16'h0070, lz:1'b1, blink_en:1'b0, mask:4'h0, hex:1'b0,
                   on:4'b0011, seg:{SX, SX, S7, S0}, ncyc:16};
        tbl[2] = '{digits:16'h0000, lz:1'b1, blink_en:1'b0, mask:4'h0, hex:1'b0,
                   on:4'b0001, seg:{SX, SX, SX, S0}, ncyc:16};
        tbl[3] = '{digits:16'h0000, lz:1'b0, blink_en:1'b0, mask:4'h0, hex:1'b0,
                   on:4'hF, seg:{S0, S0, S0, S0}, ncyc:16};
        tbl[4] = '{digits:16'h0400, lz:1'b1, blink_en:1'b0, mask:4'h0, hex:1'b0,
                   on:4'b0111, seg:{SX, S4, S0, S0}, ncyc:16};
        tbl[5] = '{digits:16'hABCF, lz:1'b0, blink_en:1'b0, mask:4'h0, hex:1'b0,
                   on:4'hF, seg:{SX, SX, SX, SX}, ncyc:16};
        tbl[6] = '{digits:16'hABCF, lz:1'b0, blink_en:1'b0, mask:4'h0, hex:1'b1,
                   on:4'hF, seg:{SA, SB, SC, SF}, ncyc:16};
        tbl[7] = '{digits:16'h1234, lz:1'b0, blink_en:1'b1, mask:4'b0010, hex:1'b0,
                   on:4'hF, seg:{S1, S2, S3, S4}, ncyc:80};

        apply(tbl[0]);
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            apply(tbl[i]);
            do_reset();
            for (int c = 0; c < tbl[i].ncyc; c++) step(tbl[i]);
        end

        // Digit 0 changes 4 -> 9 in the middle of its SHOW window.
        v = tbl[0];
        apply(v);
        do_reset();
        step(v);
        step(v);
        bus0.digits = 16'h1239;
        v.digits    = 16'h1239;
        v.seg[0]    = S9;
        step(v);
        check("midslot", {bus0.an, bus0.seg}, {4'hE, S9});
        step(v);

        // Asynchronous reset between edges while a digit is showing.
        v = tbl[0];
        apply(v);
        do_reset();
        for (int c = 0; c < 6; c++) step(v);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", {bus0.an, bus0.seg}, {4'hF, SX});
        @(negedge clk);
        rst = 1'b0;
        k   = 0;
        for (int c = 0; c < 6; c++) step(v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
